// File: rtl/delta_sigma_decoder.sv
// Sinc^2 (2nd-order CIC) decimator recovering an unsigned word from a unipolar
// pulse-density bitstream, with output saturation, valid strobe and settled flag.
module delta_sigma_decoder #(
  parameter int unsigned bits           = 16,
  parameter int unsigned decimationLog2 = 8
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            bitIn,
  input  logic            enable,
  output logic [bits-1:0] out,
  output logic            outValid,
  output logic            settled
);

  localparam int unsigned L     = decimationLog2;
  localparam int unsigned W     = 2 * L + 1;
  localparam int unsigned SHIFT = 2 * L - bits;

  localparam logic [W-1:0] OUT_MAX = {{(W - bits){1'b0}}, {bits{1'b1}}};

  typedef enum logic [1:0] {
    FILL_FIRST,
    FILL_SECOND,
    FILTER_SETTLED
  } fill_state_t;

  fill_state_t state, state_next;

  logic [W-1:0] i1, i2;
  logic [W-1:0] i1_next, i2_next;
  logic [W-1:0] d1, d2;
  logic [W-1:0] snapshot;
  logic [W-1:0] c1, c2, c2_scaled;
  logic [L-1:0] phase;
  logic         decimate;
  logic         decimate_now;
  logic [bits-1:0] out_next;

  // Integrator updates; all arithmetic wraps modulo 2^W by design.
  always_comb begin
    i1_next      = i1 + {{(W - 1){1'b0}}, bitIn};
    i2_next      = i2 + i1_next;
    decimate_now = enable && (phase == '1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      i1    <= '0;
      i2    <= '0;
      phase <= '0;
    end else if (enable) begin
      i1    <= i1_next;
      i2    <= i2_next;
      phase <= phase + 1'b1;
    end
  end

  // The snapshot decouples the comb from integrators that keep running.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      snapshot <= '0;
      decimate <= 1'b0;
    end else begin
      decimate <= decimate_now;
      if (decimate_now) begin
        snapshot <= i2_next;
      end
    end
  end

  always_comb begin
    c1        = snapshot - d1;
    c2        = c1 - d2;
    c2_scaled = c2 >> SHIFT;
    out_next  = (c2_scaled > OUT_MAX) ? '1 : c2_scaled[bits-1:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      d1       <= '0;
      d2       <= '0;
      out      <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= decimate;
      if (decimate) begin
        d1  <= snapshot;
        d2  <= c1;
        out <= out_next;
      end
    end
  end

  // The first output only sees half of the triangular impulse response.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= FILL_FIRST;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (decimate) begin
      unique case (state)
        FILL_FIRST:     state_next = FILL_SECOND;
        FILL_SECOND:    state_next = FILTER_SETTLED;
        FILTER_SETTLED: state_next = FILTER_SETTLED;
        default:        state_next = FILL_FIRST;
      endcase
    end
  end

  assign settled = (state == FILTER_SETTLED);

endmodule

// File: tb/tb_delta_sigma_decoder.sv
// Scoreboard bench for delta_sigma_decoder at default parameters (bits=16, R=256).
module tb_delta_sigma_decoder;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        bitIn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] out;
  logic        outValid;
  logic        settled;

  delta_sigma_decoder #(
    .bits(16),
    .decimationLog2(8)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bitIn(bitIn),
    .enable(enable),
    .out(out),
    .outValid(outValid),
    .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned value;
    int unsigned tol;
    bit          settled;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  logic [15:0] enc_acc = '0;
  int          diff;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid must match the next queued expectation.
  always @(negedge clk) begin
    if (outValid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: cycle %0d out=%0d, no valid expected", cyc, out);
      end else begin
        cur  = sb.pop_front();
        diff = int'(out) - int'(cur.value);
        if (diff < 0) diff = -diff;
        tests++;
        if (diff > int'(cur.tol)) begin
          fails++;
          $display("FAIL %s value: got %0d, expected %0d (tol %0d)", cur.name, out, cur.value, cur.tol);
        end
        tests++;
        if (settled !== cur.settled) begin
          fails++;
          $display("FAIL %s settled: got %b, expected %b", cur.name, settled, cur.settled);
        end
        tests++;
        if (cyc != cur.cyc) begin
          fails++;
          $display("FAIL %s timing: valid at cycle %0d, expected %0d", cur.name, cyc, cur.cyc);
        end
      end
    end
  end

  task automatic expect_valid(input string name, input int unsigned value,
                              input int unsigned tol, input bit s, input int unsigned rel);
    exp_t e;
    e.name = name; e.value = value; e.tol = tol; e.settled = s; e.cyc = c0 + rel;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (out !== 16'd0 || outValid !== 1'b0 || settled !== 1'b0) begin
      fails++;
      $display("FAIL %s: out=%0d outValid=%b settled=%b, expected all 0", name, out, outValid, settled);
    end
  endtask

  // Modes: 0 const 1, 1 const 0, 2 alt 1/0, 3 alt 0/1, 4 first-order encoder 0x4000,
  // 5 bitIn=1 with enable toggling 1/0.
  task automatic set_inputs(input int mode, input int unsigned k);
    logic [16:0] sum;
    enable = 1'b1;
    case (mode)
      0: bitIn = 1'b1;
      1: bitIn = 1'b0;
      2: bitIn = (k % 2 == 0);
      3: bitIn = (k % 2 == 1);
      4: begin
        sum     = {1'b0, enc_acc} + 17'h04000;
        enc_acc = sum[15:0];
        bitIn   = sum[16];
      end
      default: begin
        bitIn  = 1'b1;
        enable = (k % 2 == 0);
      end
    endcase
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    #1 resetN = 1'b0;
    #1 check_zero(name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s pending: %0d expected valids never seen, expected 0", name, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset(input int mode);
    enc_acc = '0;
    @(negedge clk);
    set_inputs(mode, 0);
    resetN = 1'b1;
    c0 = cyc;
  endtask

  task automatic drive(input int mode, input int unsigned ncyc);
    for (int unsigned k = 1; k < ncyc; k++) begin
      @(negedge clk);
      set_inputs(mode, k);
    end
    @(negedge clk);
    enable = 1'b0;
    bitIn  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int unsigned n = 0; n < 600 && sb.size() != 0; n++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s timeout: %0d valids outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1 check_zero("power_up");

    apply_reset("reset_t1");
    release_reset(0);
    expect_valid("ones_v1", 32896, 0, 1'b0, 257);
    expect_valid("ones_v2", 65535, 0, 1'b1, 513);
    expect_valid("ones_v3", 65535, 0, 1'b1, 769);
    expect_valid("ones_v4", 65535, 0, 1'b1, 1025);
    drive(0, 1024);
    drain("ones");

    apply_reset("reset_t2");
    release_reset(1);
    expect_valid("zeros_v1", 0, 0, 1'b0, 257);
    expect_valid("zeros_v2", 0, 0, 1'b1, 513);
    expect_valid("zeros_v3", 0, 0, 1'b1, 769);
    drive(1, 768);
    drain("zeros");

    apply_reset("reset_t3");
    release_reset(2);
    expect_valid("alt10_v1", 16512, 0, 1'b0, 257);
    expect_valid("alt10_v2", 32768, 0, 1'b1, 513);
    expect_valid("alt10_v3", 32768, 0, 1'b1, 769);
    drive(2, 768);
    drain("alt10");

    apply_reset("reset_t4");
    release_reset(3);
    expect_valid("alt01_v1", 16384, 0, 1'b0, 257);
    expect_valid("alt01_v2", 32768, 0, 1'b1, 513);
    expect_valid("alt01_v3", 32768, 0, 1'b1, 769);
    drive(3, 768);
    drain("alt01");

    apply_reset("reset_t5");
    release_reset(4);
    expect_valid("enc_v1", 8128, 0, 1'b0, 257);
    expect_valid("enc_v2", 16384, 1, 1'b1, 513);
    expect_valid("enc_v3", 16384, 1, 1'b1, 769);
    expect_valid("enc_v4", 16384, 1, 1'b1, 1025);
    drive(4, 1024);
    drain("encoder");

    apply_reset("reset_t6");
    release_reset(5);
    expect_valid("toggle_v1", 32896, 0, 1'b0, 512);
    expect_valid("toggle_v2", 65535, 0, 1'b1, 1024);
    drive(5, 1023);
    drain("toggle");

    apply_reset("reset_t7");
    release_reset(0);
    expect_valid("pre_reset_v1", 32896, 0, 1'b0, 257);
    drive(0, 356);
    apply_reset("mid_window_reset");
    release_reset(0);
    expect_valid("post_reset_v1", 32896, 0, 1'b0, 257);
    drive(0, 256);
    drain("post_reset");

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/delta_sigma_decoder.md
Name: delta_sigma_decoder

Overview:
- Receive end of the 1-bit delta-sigma link: recovers a multi-bit unsigned value from a pulse-density bitstream.
- The bitstream is the same format the DeltaSigma DAC module drives onto pinX/pinY.
- Implemented as a 2nd-order CIC (sinc^2) decimator with output saturation, a one-cycle valid strobe and a filter-settled flag.
- Used for loopback self-test of the Lorenz display chain and for reading back externally generated pulse-density signals.

Parameters:
- bits, 16, output word width; bitstream density d maps to approximately d * 2^bits.
- decimationLog2, 8, log2 of decimation ratio R (R = 256 default); constraint 2*decimationLog2 >= bits.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetN  input  1  reset, asynchronous, active-low.
- bitIn  input  1  pulse-density bitstream; 1 counts as +1, 0 counts as 0 (unipolar).
- enable  input  1  sample qualifier; bitIn is consumed only on edges where enable=1.
- out  output  bits  decoded unsigned value.
- outValid  output  1  one-cycle pulse when out updates.
- settled  output  1  high once out reflects a fully populated filter window.

Behaviour:
- Reset (resetN=0, acts immediately, no clock needed):
  - Integrators i1, i2, comb delays d1, d2, snapshot, phase counter, decimate flag all cleared to 0.
  - out=0, outValid=0, settled=0.
  - Reset mid-window discards the partial window; the state after release is identical to power-up.
- Widths and arithmetic:
  - L = decimationLog2, W = 2L+1.
  - i1, i2, d1, d2 and the comb results are W bits wide.
  - All integrator and comb arithmetic is modulo 2^W; wrap-around is intended and must not be saturated.
- Integrate, on each edge with enable=1:
  - i1 <= i1 + bitIn
  - i2 <= i2 + (i1 + bitIn)
  - phase <= phase + 1, modulo R.
- Enable low: i1, i2 and phase hold. The comb stage still completes if a decimate is pending.
- Decimate (edge E), when enable=1 and phase==R-1:
  - Snapshot <= the new i2 value, i.e. i2 + i1 + bitIn.
  - Decimate flag set for one cycle.
- Comb (edge E+1), when the decimate flag is set; runs regardless of enable:
  - c1 = snapshot - d1
  - c2 = c1 - d2
  - d1 <= snapshot, d2 <= c1.
  - out <= min(c2 >> (2L - bits), 2^bits - 1); c2 is treated as unsigned, range 0..R^2.
  - outValid <= 1 for exactly this cycle, 0 otherwise.
- Latency: outValid is high in the cycle after the edge that consumed the R-th sample of the window.
- Output spacing: R enabled samples per valid.
- settled: rises together with the 2nd outValid after reset and stays high until the next reset. The first output covers only half the triangle response.
- out holds its value between valids.
- Simultaneous events:
  - A decimate at E and integration at E+1 proceed in parallel. The snapshot isolates the comb from the running integrators.
  - A new decimate cannot occur before the previous comb completes, because R >= 2.
- Saturation: an all-ones input gives c2 = R^2. With 2L = bits this clamps to 2^bits - 1 (65535 at defaults). No other overflow is possible.

Test Plan:
- Defaults, bitIn=1 constant, enable=1:
  - 1st outValid 257 cycles after reset release, out=32896, settled=0.
  - 2nd valid 256 cycles later, out=65535 (saturated), settled=1.
  - All subsequent outputs = 65535.
- bitIn=0 constant: outValid every 256 cycles, out=0; settled rises on the 2nd valid.
- bitIn alternating 1,0 from reset: out=32768 exactly from the 2nd valid onward, independent of starting phase.
- bitIn driven by a DeltaSigma (bits=16) encoder with input 0x4000: steady-state out=16384 ±1.
- enable toggled 1,0,1,0 with bitIn=1: valids spaced 512 cycles, values 32896 then 65535. Integrators provably hold on enable=0 cycles.
- Reset mid-window (resetN low at cycle 100 of the 2nd window, released 3 cycles later):
  - out, outValid and settled go 0 without a clock edge.
  - Next valid comes 257 cycles after release with out=32896, settled=0.
